auto_parkcalc_hls_deadlock_monitor_param: RTL and testbench

Parametrised deadlock monitor for the auto_parkcalc HLS design. It combines any number of AXI-Stream block flags, sub-instance idle/block pairs and child-monitor outputs into one raw stall condition. A stall must persist for a programmable number of cycles before `block` is raised; the monitor can be sticky or self-clearing and counts deadlock events. Instances sit in the same hierarchy slots as the existing fixed-width monitors, with child `block` outputs chained into a parent's `sub_block`.

---
 rtl/auto_parkcalc_hls_deadlock_monitor_param.sv | 164 ++++++++++++++++
 tb/tb_auto_parkcalc_hls_deadlock_monitor_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/auto_parkcalc_hls_deadlock_monitor_param.sv
// auto_parkcalc_hls_deadlock_monitor_param
// Parametrised deadlock monitor. It ORs AXIS stall flags, an aggregated
// sub-instance stall term and child-monitor block outputs into one raw stall.
// The raw stall must persist THRESH consecutive cycles before block is raised.
// Optional feature macro: DEADLOCK_MON_CAUSE_EN. When it is defined, the raw
// vector is captured into block_cause on each lock entry. When it is not
// defined, block_cause is tied to 0.
// Handshake: there is none. All inputs are level flags sampled on every
// rising clock edge, and every output is registered.
module auto_parkcalc_hls_deadlock_monitor_param #(
  parameter int N_AXIS = 3,
  parameter int N_INST = 2,
  parameter int N_SUB  = 1,
  parameter int THRESH = 1,
  parameter int STICKY = 0,
  parameter int EVT_W  = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_AXIS-1:0]                    axis_block_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_idle_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_block_sigs,
  input  logic [((N_SUB > 0) ? N_SUB : 1)-1:0]   sub_block,
  input  logic                                 clear,
  output logic                                 block,
  output logic [N_AXIS+N_SUB:0]                block_cause,
  output logic [EVT_W-1:0]                     event_count,
  output logic [1:0]                           dbg_state
);

  localparam int CAUSE_W = N_AXIS + N_SUB + 1;
  localparam int CW      = $clog2(THRESH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_enter;
  logic               w_inst_stall;
  logic [CAUSE_W-1:0] w_raw_vec;
  logic               w_raw;
  logic [EVT_W-1:0]   r_evt;

  // Sub-instance stall: every instance is idle or blocked, and at least one is blocked
  generate
    if (N_INST > 0) begin : g_inst
      assign w_inst_stall = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
    end else begin : g_noinst
      assign w_inst_stall = 1'b0;
    end
  endgenerate

  // Raw stall vector, with the child-monitor term present only when children exist
  generate
    if (N_SUB > 0) begin : g_sub
      assign w_raw_vec = {sub_block, axis_block_sigs, w_inst_stall};
    end else begin : g_nosub
      assign w_raw_vec = {axis_block_sigs, w_inst_stall};
    end
  endgenerate

  assign w_raw = |w_raw_vec;

  // State and stall-counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: clear wins, then the IDLE/COUNT/LOCKED stall qualification
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter     = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_raw && (THRESH == 1)) begin
            w_state_nxt = S_LOCKED;
            w_cnt_nxt   = '0;
            w_enter     = 1'b1;
          end else if (w_raw) begin
            w_state_nxt = S_COUNT;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        S_COUNT: begin
          if (!w_raw) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CW'(THRESH - 1)) begin
            w_state_nxt = S_LOCKED;
            w_cnt_nxt   = '0;
            w_enter     = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        S_LOCKED: begin
          // A sticky lock is held until clear; a non-sticky lock releases when the stall ends
          if ((STICKY == 0) && !w_raw) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Saturating count of lock entries
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_evt <= '0;
    end else if (clear) begin
      r_evt <= '0;
    end else if (w_enter && (r_evt != {EVT_W{1'b1}})) begin
      r_evt <= r_evt + EVT_W'(1);
    end
  end

`ifdef DEADLOCK_MON_CAUSE_EN
  logic [CAUSE_W-1:0] r_cause;

  // Capture the raw vector that caused the lock, held until the next entry or clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cause <= '0;
    end else if (clear) begin
      r_cause <= '0;
    end else if (w_enter) begin
      r_cause <= w_raw_vec;
    end
  end

  assign block_cause = r_cause;
`else
  assign block_cause = '0;
`endif

  assign block       = (r_state == S_LOCKED);
  assign event_count = r_evt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_monitor_param.sv
// Bench for auto_parkcalc_hls_deadlock_monitor_param. Three instances share one
// input stream: A (THRESH=4, non-sticky), B (THRESH=3, sticky) and
// C (THRESH=1, non-sticky, 2-bit event counter). Each instance is compared
// against a run-length reference model.
module tb_auto_parkcalc_hls_deadlock_monitor_param;

  logic       clock;
  logic       reset;
  logic [2:0] axis;
  logic [1:0] idle;
  logic [1:0] iblk;
  logic       sub;
  logic       clr;

  logic [2:0]      blk;
  logic [2:0][4:0] cause;
  logic [2:0][1:0] dbg;
  logic [7:0]      evt_a;
  logic [7:0]      evt_b;
  logic [1:0]      evt_c;

  int n_checks;
  int n_fail;

  // Reference model state, one entry per instance
  int         thresh [3] = '{4, 3, 1};
  int         sticky [3] = '{0, 1, 0};
  int         evt_max[3] = '{255, 255, 3};
  int         m_run  [3];
  bit         m_lock [3];
  int         m_evt  [3];
  logic [4:0] m_cause[3];

  auto_parkcalc_hls_deadlock_monitor_param #(
    .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(4), .STICKY(0), .EVT_W(8)
  ) u_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(blk[0]),
    .block_cause(cause[0]), .event_count(evt_a), .dbg_state(dbg[0])
  );

  auto_parkcalc_hls_deadlock_monitor_param #(
    .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(3), .STICKY(1), .EVT_W(8)
  ) u_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(blk[1]),
    .block_cause(cause[1]), .event_count(evt_b), .dbg_state(dbg[1])
  );

  auto_parkcalc_hls_deadlock_monitor_param #(
    .N_AXIS(3), .N_INST(2), .N_SUB(1), .THRESH(1), .STICKY(0), .EVT_W(2)
  ) u_c (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(blk[2]),
    .block_cause(cause[2]), .event_count(evt_c), .dbg_state(dbg[2])
  );

  // Clock generation
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_evt(input int d);
    case (d)
      0:       return evt_a;
      1:       return evt_b;
      default: return {6'd0, evt_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_run[d]   = 0;
      m_lock[d]  = 1'b0;
      m_evt[d]   = 0;
      m_cause[d] = '0;
    end
  endtask

  // The stall condition as a whole: a consecutive run of high raw samples of
  // length THRESH locks the monitor.
  task automatic model_update();
    logic       inst_stall;
    logic [4:0] rv;
    inst_stall = (&(idle | iblk)) & (|iblk);
    rv = {sub, axis, inst_stall};
    for (int d = 0; d < 3; d++) begin
      if (clr) begin
        m_lock[d] = 1'b0; m_run[d] = 0; m_evt[d] = 0; m_cause[d] = '0;
      end else if (m_lock[d] && (sticky[d] == 1 || rv != 0)) begin
        // lock held
      end else if (rv == 0) begin
        m_lock[d] = 1'b0; m_run[d] = 0;
      end else begin
        m_run[d]++;
        if (m_run[d] >= thresh[d]) begin
          m_lock[d]  = 1'b1;
          m_run[d]   = 0;
          m_cause[d] = rv;
          if (m_evt[d] < evt_max[d]) m_evt[d]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [4:0] exp_cause;
    for (int d = 0; d < 3; d++) begin
`ifdef DEADLOCK_MON_CAUSE_EN
      exp_cause = m_cause[d];
`else
      exp_cause = '0;
`endif
      check($sformatf("d%0d_block", d), {31'd0, blk[d]}, {31'd0, m_lock[d]});
      check($sformatf("d%0d_evt", d), {24'd0, dut_evt(d)}, m_evt[d]);
      check($sformatf("d%0d_cause", d), {27'd0, cause[d]}, {27'd0, exp_cause});
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge
  task automatic step(input logic [2:0] ax, input logic [1:0] id, input logic [1:0] bk,
                      input logic sb, input logic cl);
    axis = ax; idle = id; iblk = bk; sub = sb; clr = cl;
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  // Assert reset between clock edges and confirm the outputs drop before any edge
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_d%0d_block", tag, d), {31'd0, blk[d]}, 32'd0);
      check($sformatf("%s_d%0d_evt", tag, d), {24'd0, dut_evt(d)}, 32'd0);
      check($sformatf("%s_d%0d_cause", tag, d), {27'd0, cause[d]}, 32'd0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] ax;
    logic [1:0] id;
    logic [1:0] bk;
    logic       sb;
    int         len;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; axis = '0; idle = '0; iblk = '0; sub = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b1;

    // Single AXIS flag held for four cycles locks A on the 4th edge
    for (int k = 0; k < 4; k++) step(3'b010, 2'b00, 2'b00, 1'b0, 1'b0);
    check("dirA_lock", {31'd0, blk[0]}, 32'd1);
    check("dirA_evt", {24'd0, evt_a}, 32'd1);
    step(3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Three high, one low, four high: only the second burst locks A
    for (int k = 0; k < 3; k++) step(3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
    step(3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    check("burst_nolock", {31'd0, blk[0]}, 32'd0);
    for (int k = 0; k < 4; k++) step(3'b100, 2'b00, 2'b00, 1'b0, 1'b0);
    check("burst_lock", {31'd0, blk[0]}, 32'd1);

    // Instance-stall term alone, then released
    for (int k = 0; k < 5; k++) step(3'b000, 2'b01, 2'b10, 1'b0, 1'b0);
    step(3'b000, 2'b01, 2'b00, 1'b0, 1'b0);
    check("inst_release", {31'd0, blk[0]}, 32'd0);

    // Sticky B stays locked with raw low until clear
    step(3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    check("sticky_hold", {31'd0, blk[1]}, 32'd1);
    step(3'b000, 2'b00, 2'b00, 1'b0, 1'b1);
    check("sticky_clear", {31'd0, blk[1]}, 32'd0);
    step(3'b000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Five lock/release pairs saturate C's two-bit counter
    for (int k = 0; k < 5; k++) begin
      step(3'b000, 2'b00, 2'b00, 1'b1, 1'b0);
      step(3'b000, 2'b00, 2'b00, 1'b0, 1'b0);
    end
    check("sat_c", {30'd0, evt_c}, 32'd3);

    // Reset mid-count, then a fresh full count is needed
    step(3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
    step(3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
    async_reset("rst_count");
    for (int k = 0; k < 3; k++) step(3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
    check("rst_fresh", {31'd0, blk[0]}, 32'd0);
    step(3'b001, 2'b00, 2'b00, 1'b0, 1'b0);
    // Reset while locked
    async_reset("rst_locked");

    // Randomised held segments with occasional clear and reset
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        ax = '0; sb = 1'b0;
      end else begin
        ax = 3'($urandom); sb = ($urandom_range(0, 3) == 0);
      end
      id  = 2'($urandom);
      bk  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(ax, id, bk, sb, ($urandom_range(0, 25) == 0));
      if (seg % 50 == 25) async_reset("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit reached");
  end

endmodule
